// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce bank (50 MHz clk defaults).
// DEBOUNCE_CHECK_CNT_W stops elaboration when the stability counter is too narrow.
`ifndef DEBOUNCE_PKG_SV
`define DEBOUNCE_PKG_SV

`define DEBOUNCE_CHECK_CNT_W(cnt_w, stable_cnt) \
    if ((64'd1 << (cnt_w)) <= 64'(stable_cnt)) begin : g_cnt_w_too_small \
        $error("debounce: 2**CNT_W must exceed STABLE_CNT"); \
    end

package debounce_pkg;

    localparam int STABLE_CNT_DEF = 50_000;      // 1 ms
    localparam int REPEAT_DLY_DEF = 25_000_000;  // 500 ms
    localparam int REPEAT_PER_DEF = 5_000_000;   // 100 ms

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`endif

// File: rtl/debounce_bank_if.sv
// Pin-side and event-side signals of the debounce bank.
interface debounce_bank_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] inp;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press_p;
    logic [N_CH-1:0] release_p;

    modport master (output inp, input level, press_p, release_p);
    modport slave  (input inp, output level, press_p, release_p);
endinterface

// File: rtl/debounce_ch.sv
// One debounce channel: 2-FF sync, stability counter, level and edge pulses.
// Auto-repeat on press_p is built only with DEBOUNCE_AUTO_REPEAT_EN defined.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT    = STABLE_CNT_DEF,
    parameter int CNT_W         = 16,
    parameter int ACTIVE_LOW_IN = 0,
    parameter int REPEAT_DLY    = REPEAT_DLY_DEF,
    parameter int REPEAT_PER    = REPEAT_PER_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inp,
    output logic level,
    output logic press_p,
    output logic release_p
);
    if (STABLE_CNT < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
        $error("debounce_ch: STABLE_CNT, REPEAT_DLY and REPEAT_PER must be >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic             INV      = (ACTIVE_LOW_IN != 0);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             ev;

    // A debounced transition happens on this edge.
    assign ev = (s2 != level) && (cnt == CNT_LAST);

`ifdef DEBOUNCE_AUTO_REPEAT_EN
    localparam int            RW       = clog2(max_int(REPEAT_DLY, REPEAT_PER)) + 1;
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

    logic [RW-1:0] rcnt;
    logic          rep_phase;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            level     <= 1'b0;
            cnt       <= '0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
            rcnt      <= '0;
            rep_phase <= 1'b0;
`endif
        end else begin
            s1        <= inp ^ INV;
            s2        <= s1;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            if (ev) begin
                level     <= s2;
                cnt       <= '0;
                press_p   <= s2;
                release_p <= ~s2;
            end else if (s2 == level) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
`ifdef DEBOUNCE_AUTO_REPEAT_EN
            // First repeat waits REPEAT_DLY, later ones REPEAT_PER.
            if (!level || ev) begin
                rcnt      <= '0;
                rep_phase <= 1'b0;
            end else if (rcnt == (rep_phase ? PER_LAST : DLY_LAST)) begin
                press_p   <= 1'b1;
                rcnt      <= '0;
                rep_phase <= 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
`endif
        end
    end
endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounce channels; wiring only.
// Optional auto-repeat: define DEBOUNCE_AUTO_REPEAT_EN.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int STABLE_CNT    = STABLE_CNT_DEF,
    parameter int CNT_W         = 16,
    parameter int ACTIVE_LOW_IN = 0,
    parameter int REPEAT_DLY    = REPEAT_DLY_DEF,
    parameter int REPEAT_PER    = REPEAT_PER_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    debounce_bank_if.slave  bus
);
    `DEBOUNCE_CHECK_CNT_W(CNT_W, STABLE_CNT)

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .STABLE_CNT    (STABLE_CNT),
            .CNT_W         (CNT_W),
            .ACTIVE_LOW_IN (ACTIVE_LOW_IN),
            .REPEAT_DLY    (REPEAT_DLY),
            .REPEAT_PER    (REPEAT_PER)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .inp       (bus.inp[i]),
            .level     (bus.level[i]),
            .press_p   (bus.press_p[i]),
            .release_p (bus.release_p[i])
        );
    end
endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: 4 channels, STABLE_CNT=4.
// Expected pulses are queued with their edge number when stimulus is driven.
module tb_debounce_bank;
    localparam int N_CH = 4;
    localparam int LAT  = 5;   // first-sample edge to level change
    localparam int RDLY = 10;
    localparam int RPER = 3;

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] r;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    ev_t  sb[$];

    debounce_bank_if #(.N_CH(N_CH)) bus();

    debounce_bank #(
        .N_CH          (N_CH),
        .STABLE_CNT    (4),
        .CNT_W         (3),
        .ACTIVE_LOW_IN (0),
        .REPEAT_DLY    (RDLY),
        .REPEAT_PER    (RPER)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Scoreboard: every pulse must match the queue head at the exact edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL missed_pulse: expected press %b release %b at edge %0d, absent through edge %0d",
                     sb[0].p, sb[0].r, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if ((bus.press_p | bus.release_p) != 4'b0) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: got press %b release %b at edge %0d, required none",
                         bus.press_p, bus.release_p, cyc);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (cyc !== e.cyc || bus.press_p !== e.p || bus.release_p !== e.r) begin
                    fails++;
                    $display("FAIL pulse: got press %b release %b at edge %0d, required press %b release %b at edge %0d",
                             bus.press_p, bus.release_p, cyc, e.p, e.r, e.cyc);
                end
            end
        end
    end

    function automatic void push_ev(int c, logic [3:0] p, logic [3:0] r);
        ev_t e;
        e.cyc = c;
        e.p   = p;
        e.r   = r;
        sb.push_back(e);
    endfunction

    task automatic wait_cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_drained(string name);
        wait_cycles(4);
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL %s_drained: %0d expected pulses outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        bus.inp = 4'b0;
        rst_n   = 1'b0;
        wait_cycles(3);
        tests += 3;
        if (bus.level !== 4'b0) begin
            fails++;
            $display("FAIL reset_level: got %b, required 0000", bus.level);
        end
        if (bus.press_p !== 4'b0) begin
            fails++;
            $display("FAIL reset_press: got %b, required 0000", bus.press_p);
        end
        if (bus.release_p !== 4'b0) begin
            fails++;
            $display("FAIL reset_release: got %b, required 0000", bus.release_p);
        end
        rst_n = 1'b1;
        wait_cycles(12);
        test_drained("reset_idle");
    endtask

    task automatic test_clean_press;
        bus.inp[0] = 1'b1;
        push_ev(cyc + 1 + LAT, 4'b0001, 4'b0000);
        wait_cycles(8);
        tests++;
        if (bus.level !== 4'b0001) begin
            fails++;
            $display("FAIL clean_level_high: got %b, required 0001", bus.level);
        end
        bus.inp[0] = 1'b0;
        push_ev(cyc + 1 + LAT, 4'b0000, 4'b0001);
        wait_cycles(8);
        tests++;
        if (bus.level !== 4'b0000) begin
            fails++;
            $display("FAIL clean_level_low: got %b, required 0000", bus.level);
        end
        test_drained("clean");
    endtask

    task automatic test_glitch;
        bus.inp[1] = 1'b1;
        wait_cycles(3);
        bus.inp[1] = 1'b0;
        wait_cycles(8);
        tests++;
        if (bus.level !== 4'b0000) begin
            fails++;
            $display("FAIL glitch_level: got %b, required 0000", bus.level);
        end
        bus.inp[1] = 1'b1;
        push_ev(cyc + 1 + LAT, 4'b0010, 4'b0000);
        wait_cycles(5);
        bus.inp[1] = 1'b0;
        push_ev(cyc + 1 + LAT, 4'b0000, 4'b0010);
        wait_cycles(8);
        test_drained("glitch");
    endtask

    task automatic test_bounce;
        logic [4:0] pat;
        pat = 5'b10101;
        for (int i = 4; i >= 0; i--) begin
            bus.inp[2] = pat[i];
            if (i == 0) push_ev(cyc + 1 + LAT, 4'b0100, 4'b0000);
            wait_cycles(1);
        end
        wait_cycles(8);
        tests++;
        if (bus.level !== 4'b0100) begin
            fails++;
            $display("FAIL bounce_level: got %b, required 0100", bus.level);
        end
        bus.inp[2] = 1'b0;
        push_ev(cyc + 1 + LAT, 4'b0000, 4'b0100);
        wait_cycles(8);
        test_drained("bounce");
    endtask

    task automatic test_simultaneous;
        bus.inp = 4'b1001;
        push_ev(cyc + 1 + LAT, 4'b1001, 4'b0000);
        wait_cycles(8);
        tests++;
        if (bus.level !== 4'b1001) begin
            fails++;
            $display("FAIL simul_level: got %b, required 1001", bus.level);
        end
        bus.inp = 4'b0000;
        push_ev(cyc + 1 + LAT, 4'b0000, 4'b1001);
        wait_cycles(8);
        test_drained("simul");
    endtask

    task automatic test_reset_mid;
        bus.inp[3] = 1'b1;
        push_ev(cyc + 1 + LAT, 4'b1000, 4'b0000);
        wait_cycles(8);
        bus.inp[0] = 1'b1;
        wait_cycles(2);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.level !== 4'b0000 || bus.press_p !== 4'b0 || bus.release_p !== 4'b0) begin
            fails++;
            $display("FAIL reset_mid_async: got level %b press %b release %b, required all 0",
                     bus.level, bus.press_p, bus.release_p);
        end
        wait_cycles(2);
        rst_n = 1'b1;
        push_ev(cyc + 1 + LAT, 4'b1001, 4'b0000);
        wait_cycles(8);
        tests++;
        if (bus.level !== 4'b1001) begin
            fails++;
            $display("FAIL reset_mid_level: got %b, required 1001", bus.level);
        end
        bus.inp = 4'b0000;
        push_ev(cyc + 1 + LAT, 4'b0000, 4'b1001);
        wait_cycles(8);
        test_drained("reset_mid");
    endtask

    task automatic test_auto_repeat;
        int t;
        bus.inp[0] = 1'b1;
        t = cyc + 1 + LAT;
        push_ev(t, 4'b0001, 4'b0000);
`ifdef DEBOUNCE_AUTO_REPEAT_EN
        push_ev(t + RDLY, 4'b0001, 4'b0000);
        push_ev(t + RDLY + RPER, 4'b0001, 4'b0000);
        push_ev(t + RDLY + 2 * RPER, 4'b0001, 4'b0000);
        push_ev(t + RDLY + 3 * RPER, 4'b0001, 4'b0000);
`endif
        wait_cycles(20);
        bus.inp[0] = 1'b0;
        push_ev(cyc + 1 + LAT, 4'b0000, 4'b0001);
        wait_cycles(10);
        test_drained("repeat");
    endtask

    initial begin
        bus.inp = 4'b0;
        test_reset;
        test_clean_press;
        test_glitch;
        test_bounce;
        test_simultaneous;
        test_reset_mid;
        test_auto_repeat;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
